// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: holds all domains in reset, then releases them
// one by one in index order, waiting for each domain's synchronized ready flag.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_RDY,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_DONE,
  output logic                   SEQ_ERR,
  output logic [IDX_W-1:0]       ERR_IDX
);

  typedef enum logic [1:0] {
    S_ASSERT   = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DONE     = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_done;
  logic                   r_err;
  logic [IDX_W-1:0]       r_err_idx;
  logic [NUM_DOMAINS-1:0] r_sync [SYNC_STAGES];

  logic [NUM_DOMAINS-1:0] w_rdy_s;
  logic                   w_hold_end;
  logic                   w_tmo_end;
  logic                   w_last;
  logic [NUM_DOMAINS-1:0] w_next_mask;

  // DOMAIN_RDY crosses in from each domain's clock; plain multi-flop sync per bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= DOMAIN_RDY;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rdy_s     = r_sync[SYNC_STAGES-1];
  assign w_hold_end  = (r_cnt == CNT_WIDTH'(HOLD_CYCLES - 1));
  assign w_tmo_end   = (r_cnt == CNT_WIDTH'(TIMEOUT - 1));
  assign w_last      = (r_idx == IDX_W'(NUM_DOMAINS - 1));
  assign w_next_mask = NUM_DOMAINS'(1) << (r_idx + IDX_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_n   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else if (SW_RST_REQ) begin
      // Re-sequence wins over any same-edge ready or timeout; ERR_IDX is kept.
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (w_hold_end) begin
            r_state <= S_WAIT_ACK;
            r_rst_n <= NUM_DOMAINS'(1);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_WAIT_ACK: begin
          if (w_rdy_s[r_idx]) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_rst_n <= r_rst_n | w_next_mask;
              r_cnt   <= '0;
            end
          end else if (w_tmo_end) begin
            r_state   <= S_ERROR;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign DOMAIN_RST_N = r_rst_n;
  assign SEQ_DONE     = r_done;
  assign SEQ_ERR      = r_err;
  assign ERR_IDX      = r_err_idx;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them.
module tb_rst_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW_RST_REQ = 1'b0;
  logic [2:0] DOMAIN_RDY;
  logic [2:0] DOMAIN_RST_N;
  logic       SEQ_DONE;
  logic       SEQ_ERR;
  logic [1:0] ERR_IDX;

  logic [2:0] tie_low = 3'b000;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;

  typedef struct {
    int         at;
    logic [2:0] rn;
    logic       d;
    logic       er;
    logic [1:0] ei;
    string      nm;
  } exp_t;

  exp_t sb[$];

  rst_seq_ctrl #(
    .NUM_DOMAINS(3), .HOLD_CYCLES(4), .TIMEOUT(16), .SYNC_STAGES(2), .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .DOMAIN_RDY(DOMAIN_RDY),
    .DOMAIN_RST_N(DOMAIN_RST_N), .SEQ_DONE(SEQ_DONE), .SEQ_ERR(SEQ_ERR), .ERR_IDX(ERR_IDX)
  );

  // Loopback from each domain's reset, with per-domain stuck-low override.
  assign DOMAIN_RDY = DOMAIN_RST_N & ~tie_low;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.at != cyc || DOMAIN_RST_N !== e.rn || SEQ_DONE !== e.d ||
          SEQ_ERR !== e.er || ERR_IDX !== e.ei) begin
        n_fail++;
        $display("FAIL %s edge=%0d(want %0d): got rst_n=%b done=%b err=%b idx=%0d, want rst_n=%b done=%b err=%b idx=%0d",
                 e.nm, cyc, e.at, DOMAIN_RST_N, SEQ_DONE, SEQ_ERR, ERR_IDX, e.rn, e.d, e.er, e.ei);
      end
    end
  end

  task automatic expect_at(input int at, input logic [2:0] rn, input logic d,
                           input logic er, input logic [1:0] ei, input string nm);
    exp_t e;
    e.at = at; e.rn = rn; e.d = d; e.er = er; e.ei = ei; e.nm = nm;
    sb.push_back(e);
  endtask

  // Full clean sequence starting at edge r (reset release or request edge).
  task automatic push_seq(input int r, input logic [1:0] ei, input string nm);
    expect_at(r,      3'b000, 1'b0, 1'b0, ei, {nm, "_start"});
    expect_at(r + 3,  3'b000, 1'b0, 1'b0, ei, {nm, "_hold"});
    expect_at(r + 4,  3'b001, 1'b0, 1'b0, ei, {nm, "_rel0"});
    expect_at(r + 6,  3'b001, 1'b0, 1'b0, ei, {nm, "_wait1"});
    expect_at(r + 7,  3'b011, 1'b0, 1'b0, ei, {nm, "_rel1"});
    expect_at(r + 9,  3'b011, 1'b0, 1'b0, ei, {nm, "_wait2"});
    expect_at(r + 10, 3'b111, 1'b0, 1'b0, ei, {nm, "_rel2"});
    expect_at(r + 12, 3'b111, 1'b0, 1'b0, ei, {nm, "_predone"});
    expect_at(r + 13, 3'b111, 1'b1, 1'b0, ei, {nm, "_done"});
  endtask

  // Advance to 2ns after edge t.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // SW_RST_REQ high for exactly the edge numbered e.
  task automatic sw_req_at(input int e);
    goto(e - 1);
    SW_RST_REQ = 1'b1;
    @(posedge CLK);
    #2;
    SW_RST_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e2, e3, e4, e5, c1, e6;

    // Power-on sequence, then DONE ignores ready drops.
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    c0 = cyc;
    push_seq(c0, 2'd0, "por");
    expect_at(c0 + 20, 3'b111, 1'b1, 1'b0, 2'd0, "done_ignores_rdy");
    goto(c0 + 15);
    n_vec++;
    if (SEQ_DONE !== 1'b1 || DOMAIN_RST_N !== 3'b111) begin
      n_fail++;
      $display("FAIL direct_done: got done=%b rst_n=%b, want done=1 rst_n=111", SEQ_DONE, DOMAIN_RST_N);
    end
    tie_low = 3'b111;
    goto(c0 + 21);
    tie_low = 3'b000;

    // Re-sequence from DONE.
    e2 = c0 + 22;
    push_seq(e2, 2'd0, "swreq_done");
    sw_req_at(e2);

    // Domain 1 never ready: timeout on domain 1.
    e3 = e2 + 16;
    goto(e3 - 2);
    tie_low = 3'b010;
    expect_at(e3,      3'b000, 1'b0, 1'b0, 2'd0, "tmo_start");
    expect_at(e3 + 4,  3'b001, 1'b0, 1'b0, 2'd0, "tmo_rel0");
    expect_at(e3 + 7,  3'b011, 1'b0, 1'b0, 2'd0, "tmo_rel1");
    expect_at(e3 + 22, 3'b011, 1'b0, 1'b0, 2'd0, "tmo_pre");
    expect_at(e3 + 23, 3'b011, 1'b0, 1'b1, 2'd1, "tmo_err");
    expect_at(e3 + 30, 3'b011, 1'b0, 1'b1, 2'd1, "tmo_hold");
    sw_req_at(e3);
    goto(e3 + 24);
    n_vec++;
    if (SEQ_ERR !== 1'b1 || ERR_IDX !== 2'd1 || DOMAIN_RST_N !== 3'b011) begin
      n_fail++;
      $display("FAIL direct_tmo: got err=%b idx=%0d rst_n=%b, want err=1 idx=1 rst_n=011",
               SEQ_ERR, ERR_IDX, DOMAIN_RST_N);
    end

    // Recover from ERROR; ERR_IDX survives the request.
    e4 = e3 + 32;
    push_seq(e4, 2'd1, "recover");
    sw_req_at(e4);
    n_vec++;
    if (ERR_IDX !== 2'd1 || SEQ_ERR !== 1'b0 || DOMAIN_RST_N !== 3'b000) begin
      n_fail++;
      $display("FAIL direct_recover: got idx=%0d err=%b rst_n=%b, want idx=1 err=0 rst_n=000",
               ERR_IDX, SEQ_ERR, DOMAIN_RST_N);
    end
    tie_low = 3'b000;

    // Asynchronous RST mid-sequence, then clean restart.
    e5 = e4 + 16;
    expect_at(e5,     3'b000, 1'b0, 1'b0, 2'd1, "pre_rst_start");
    expect_at(e5 + 7, 3'b011, 1'b0, 1'b0, 2'd1, "pre_rst_011");
    expect_at(e5 + 8, 3'b000, 1'b0, 1'b0, 2'd0, "async_rst");
    sw_req_at(e5);
    goto(e5 + 8);
    RST = 1'b1;
    #1;
    n_vec++;
    if (DOMAIN_RST_N !== 3'b000 || SEQ_DONE !== 1'b0 || SEQ_ERR !== 1'b0 || ERR_IDX !== 2'd0) begin
      n_fail++;
      $display("FAIL direct_async_rst: got rst_n=%b done=%b err=%b idx=%0d, want all 0",
               DOMAIN_RST_N, SEQ_DONE, SEQ_ERR, ERR_IDX);
    end
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    c1 = cyc;
    push_seq(c1, 2'd0, "after_rst");
    goto(c1 + 14);

    // Request on the domain-2 timeout edge, then request on the final-ready edge.
    e6 = c1 + 16;
    goto(e6 - 2);
    tie_low = 3'b100;
    expect_at(e6,      3'b000, 1'b0, 1'b0, 2'd0, "t2_start");
    expect_at(e6 + 4,  3'b001, 1'b0, 1'b0, 2'd0, "t2_rel0");
    expect_at(e6 + 10, 3'b111, 1'b0, 1'b0, 2'd0, "t2_rel2");
    expect_at(e6 + 25, 3'b111, 1'b0, 1'b0, 2'd0, "t2_pre");
    expect_at(e6 + 26, 3'b000, 1'b0, 1'b0, 2'd0, "sw_beats_tmo");
    expect_at(e6 + 29, 3'b000, 1'b0, 1'b0, 2'd0, "sw_beats_tmo_hold");
    expect_at(e6 + 30, 3'b001, 1'b0, 1'b0, 2'd0, "sw_beats_tmo_rel0");
    expect_at(e6 + 33, 3'b011, 1'b0, 1'b0, 2'd0, "fin_rel1");
    expect_at(e6 + 36, 3'b111, 1'b0, 1'b0, 2'd0, "fin_rel2");
    expect_at(e6 + 38, 3'b111, 1'b0, 1'b0, 2'd0, "fin_pre");
    expect_at(e6 + 39, 3'b000, 1'b0, 1'b0, 2'd0, "sw_beats_done");
    expect_at(e6 + 43, 3'b001, 1'b0, 1'b0, 2'd0, "sw_beats_done_rel0");
    sw_req_at(e6);
    sw_req_at(e6 + 26);
    tie_low = 3'b000;
    sw_req_at(e6 + 39);
    goto(e6 + 46);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL %s: got never checked, want check at edge %0d", e.nm, e.at);
    end

    if (n_fail == 0) $display("PASS all vectors");
    else $display("FAIL %0d miscompares", n_fail);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
